// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, machine word and the memory-arbiter FSM states.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STAT_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IGRANT = 2'b01,
    DGRANT = 2'b10
  } arb_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of back-to-back data grants taken while an instruction fetch waits.
module arb_starve_ctr #(
  parameter int unsigned STARVE_W   = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat_c
);

  localparam logic [STARVE_W-1:0] MAX_VAL = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // Clear dominates increment; increment stops at the saturation value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_c = (cnt_q == MAX_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between fetch (I) and MEM-stage (D) requesters, D first with starvation guard.
// Optional MEM_ARB_STATS_EN adds saturating completed-access counters per requester class.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned STARVE_W   = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_igrants,
  output logic [31:0] stat_dgrants
`endif
);

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       ram_ok;
  logic       i_done;
  logic       d_done;
  logic       starve_clr;
  logic       starve_sat;

  assign d_req  = dREN | dWEN;
  assign ram_ok = (ramstate_t'(ramstate) == ACCESS);

  arb_starve_ctr #(
    .STARVE_W  (STARVE_W),
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (d_done & iREN),
    .clr  (starve_clr | i_done),
    .sat_c(starve_sat)
  );

  // Grant selection and RAM drive; a dropped request aborts the grant with no response.
  always_comb begin
    state_d    = state_q;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    starve_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        starve_clr = ~iREN;
        if (iREN && starve_sat) begin
          state_d = IGRANT;
        end else if (d_req) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ram_ok) begin
            dwait   = 1'b0;
            dload   = ramload;
            d_done  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ram_ok) begin
            iwait   = 1'b0;
            iload   = ramload;
            i_done  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_i_q, stat_i_d;
  logic [STAT_W-1:0] stat_d_q, stat_d_d;

  // Completed-access counters hold at all-ones rather than wrapping.
  always_comb begin
    stat_i_d = stat_i_q;
    stat_d_d = stat_d_q;
    if (i_done && (stat_i_q != '1)) stat_i_d = stat_i_q + STAT_W'(1);
    if (d_done && (stat_d_q != '1)) stat_d_d = stat_d_q + STAT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_i_q <= '0;
      stat_d_q <= '0;
    end else begin
      stat_i_q <= stat_i_d;
      stat_d_q <= stat_d_d;
    end
  end

  assign stat_igrants = stat_i_q;
  assign stat_dgrants = stat_d_q;
`endif

endmodule
